// File: rtl/sum_collect.sv
// Deserialises one LSB-first frame of WIDTH serial sum bits into a parallel sum.
// The carry presented with the final bit is latched as cout.
module sum_collect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             s_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshake: bit_valid qualifies s_in/c_in for one cycle; there is no ready,
  // so every valid bit presented while busy=1 is consumed on that rising edge.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] captured;

  // Bits above count are still zero, so OR-ing in the new bit places it at [count].
  assign captured  = shreg | (WIDTH'(s_in) << count);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state <= COLLECT;
            count <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          busy <= 1'b1;
          if (start) err <= 1'b1;
          if (bit_valid) begin
            if (count == LAST) begin
              sum   <= captured;
              cout  <= c_in;
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              count <= '0;
            end else begin
              shreg <= captured;
              count <= count + CW'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= COLLECT;
            count <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_collect.sv
// Scoreboard bench for sum_collect: drivers push expected {cout,sum} per frame,
// a negedge monitor pops and compares on every done pulse.
module tb_sum_collect;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, bit_valid, s_in, c_in;
  logic [W-1:0] sum;
  logic         cout, busy, done, err;
  logic [1:0]   dbg_state;

  sum_collect #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .s_in(s_in), .c_in(c_in), .sum(sum), .cout(cout), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];
  logic [W:0] prev_out = '0;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, exp_err = 0;
  int last_done_cyc = -1, last_err_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      prev_out = {cout, sum};
    end else begin
      if (busy && done) check("busy_done_overlap", 32'(busy & done), 32'd0);
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("frame_result", 32'({cout, sum}), 32'(exp_q.pop_front()));
      end else begin
        check("sum_hold", 32'({cout, sum}), 32'(prev_out));
      end
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      prev_out = {cout, sum};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    bit_valid = 1'(($urandom_range(0, 1)));
    s_in      = 1'(($urandom_range(0, 1)));
    c_in      = 1'(($urandom_range(0, 1)));
  endtask

  // Start cycle carries a valid bit of 1 that must be ignored.
  task automatic do_start();
    start = 1'b1; bit_valid = 1'b1; s_in = 1'b1; c_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
  endtask

  // Sends W valid bits (LSB first); gap_len idle cycles precede bit gap_pos;
  // start is raised on COLLECT cycle err_at (-1 = never).
  task automatic do_bits(input logic [W-1:0] b, input logic cy, input int gap_pos,
                         input int gap_len, input int err_at);
    int k;
    k = 0;
    exp_q.push_back({cy, b});
    for (int i = 0; i < W; i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          bit_valid = 1'b0;
          s_in  = 1'(($urandom_range(0, 1)));
          c_in  = 1'(($urandom_range(0, 1)));
          start = (k == err_at);
          if (start) exp_err++;
          k++;
          tick();
        end
      end
      bit_valid = 1'b1;
      s_in  = b[i];
      c_in  = (i == W - 1) ? cy : 1'(($urandom_range(0, 1)));
      start = (k == err_at);
      if (start) exp_err++;
      k++;
      tick();
    end
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int sc, d0, e0;
  logic [W-1:0] rb;
  logic rc;
  int gl, gp, ea;

  initial begin
    reset = 1'b0; start = 1'b0; bit_valid = 1'b0; s_in = 1'b0; c_in = 1'b0;
    tick(); tick();
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_flags", 32'({busy, done, err}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick();

    // Directed 1: 0,0,0,1 -> 1000, done in cycle 6 counting start as cycle 1.
    sc = cyc;
    do_start();
    do_bits(4'b1000, 1'b0, -1, 0, -1);
    tick();
    check("d1_done_latency", 32'(last_done_cyc - sc), 32'd5);

    // Directed 2: 1111+0001 -> sum 0000, cout 1.
    do_start();
    do_bits(4'b0000, 1'b1, -1, 0, -1);
    tick();
    check("d2_cout", 32'(cout), 32'd1);

    // Directed 3: 3-cycle gap between bits 2 and 3.
    sc = cyc;
    do_start();
    do_bits(4'b1000, 1'b0, 2, 3, -1);
    tick();
    check("d3_gap_latency", 32'(last_done_cyc - sc), 32'd8);

    // Directed 4: start in 2nd COLLECT cycle.
    d0 = done_cnt; e0 = err_cnt; sc = cyc;
    do_start();
    do_bits(4'b0110, 1'b1, -1, 0, 1);
    tick(); tick();
    check("d4_err_count", 32'(err_cnt - e0), 32'd1);
    check("d4_err_cycle", 32'(last_err_cyc - sc), 32'd3);
    check("d4_done_count", 32'(done_cnt - d0), 32'd1);

    // Directed 5: reset after 2 valid bits.
    d0 = done_cnt;
    do_start();
    bit_valid = 1'b1; s_in = 1'b1; tick();
    bit_valid = 1'b1; s_in = 1'b1; tick();
    reset = 1'b0;
    #1;
    check("d5_rst_sum", 32'(sum), 32'd0);
    check("d5_rst_cout", 32'(cout), 32'd0);
    check("d5_rst_busy", 32'(busy), 32'd0);
    check("d5_rst_state", 32'(dbg_state), 32'd0);
    tick(); tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      bit_valid = 1'b1; s_in = 1'b1; c_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    tick(); tick();
    check("d5_no_done", 32'(done_cnt - d0), 32'd0);
    check("d5_sum_zero", 32'(sum), 32'd0);
    check("d5_no_busy", 32'(busy), 32'd0);
    do_start();
    do_bits(4'b1011, 1'b0, -1, 0, -1);
    tick();

    // Directed 6: back-to-back frames, start during DONE.
    d0 = done_cnt;
    do_start();
    do_bits(4'b0101, 1'b1, -1, 0, -1);
    check("d6_done_cycle_busy", 32'({busy, done}), 32'b01);
    do_start();
    check("d6_second_busy", 32'(busy), 32'd1);
    do_bits(4'b1110, 1'b0, 1, 2, -1);
    check("d6_second_done", 32'({busy, done}), 32'b01);
    tick();
    check("d6_done_count", 32'(done_cnt - d0), 32'd2);

    // Randomised frames with gaps, stray starts and back-to-back chaining.
    do_start();
    for (int f = 0; f < 30; f++) begin
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      gl = $urandom_range(0, 3);
      gp = $urandom_range(0, W - 1);
      ea = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W + gl - 1) : -1;
      do_bits(rb, rc, gp, gl, ea);
      if (f == 29) break;
      if ($urandom_range(0, 1) == 1) begin
        do_start();
      end else begin
        idle_inputs();
        repeat ($urandom_range(1, 3)) tick();
        do_start();
      end
    end
    idle_inputs();
    tick();
    start = 1'b0; bit_valid = 1'b0;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("err_total", 32'(err_cnt), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
